// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared types, state encoding and round constants for the
//           cipher-side control responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    typedef enum logic [2:0] {
        AES_128 = 3'b001,
        AES_192 = 3'b010,
        AES_256 = 3'b100
    } key_len_e;

    // Codes are at least Hamming distance 3 apart; any other value is a fault.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b001110,
        ST_RESEED = 6'b010011,
        ST_CLEAR  = 6'b100101,
        ST_INIT   = 6'b111000,
        ST_ROUND  = 6'b011101,
        ST_FINISH = 6'b110110,
        ST_ERROR  = 6'b101011
    } aes_cipher_resp_state_e;

    localparam logic [3:0] NumRounds128 = 4'd10;
    localparam logic [3:0] NumRounds192 = 4'd12;
    localparam logic [3:0] NumRounds256 = 4'd14;

    function automatic logic [3:0] num_rounds(input logic [2:0] key_len);
        case (key_len)
            AES_192: num_rounds = NumRounds192;
            AES_256: num_rounds = NumRounds256;
            default: num_rounds = NumRounds128;
        endcase
    endfunction

    // Clear outranks key/state work; with nothing to do the request is a no-op.
    function automatic aes_cipher_resp_state_e route(input logic key_clear,
                                                     input logic data_out_clear,
                                                     input logic crypt,
                                                     input logic dec_key_gen);
        if (key_clear || data_out_clear) begin
            route = ST_CLEAR;
        end else if (crypt || dec_key_gen) begin
            route = ST_INIT;
        end else begin
            route = ST_FINISH;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_cipher_round_cnt.sv
// ============================================================================
// Module  : aes_cipher_round_cnt
// Brief   : Round counter; loads Nr from the key length and flags the last round.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_cipher_round_cnt
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] key_len_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    logic [3:0] nr_q, nr_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        nr_d  = nr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (load_i) begin
            nr_d  = num_rounds(key_len_i);
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nr_q  <= NumRounds128;
            cnt_q <= 4'd0;
        end else begin
            nr_q  <= nr_d;
            cnt_q <= cnt_d;
        end
    end

    assign round_o = cnt_q;
    assign last_o  = (cnt_q == (nr_q - 4'd1));

endmodule

`default_nettype wire

// File: rtl/aes_cipher_ctrl_resp.sv
// ============================================================================
// Module  : aes_cipher_ctrl_resp
// Brief   : Cipher-side responder for the control-FSM handshake. Optional
//           busy-cycle counter enabled by AES_CIPHER_RESP_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_cipher_ctrl_resp
    import aes_pkg::*;
#(
    parameter int SecMasking   = 1,
    parameter int PerfCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [1:0]              op_i,
    input  logic [2:0]              key_len_i,
    input  logic                    crypt_i,
    input  logic                    dec_key_gen_i,
    input  logic                    prng_reseed_i,
    input  logic                    key_clear_i,
    input  logic                    data_out_clear_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    crypt_o,
    output logic                    dec_key_gen_o,
    output logic                    prng_reseed_o,
    output logic                    key_clear_o,
    output logic                    data_out_clear_o,
    output logic                    reseed_req_o,
    input  logic                    reseed_ack_i,
    output logic                    sb_en_o,
    input  logic                    sb_done_i,
    output logic [3:0]              round_o,
    output logic                    state_we_o,
    output logic                    key_we_o,
    output logic                    state_clr_o,
    output logic                    key_clr_o,
    output logic                    alert_o,
    output logic [PerfCntWidth-1:0] busy_cycles_o
);

    aes_cipher_resp_state_e state_q, state_d;
    logic crypt_q, crypt_d, dkg_q, dkg_d, reseed_q, reseed_d;
    logic kclr_q, kclr_d, dclr_q, dclr_d, alert_q, alert_d;
    logic cnt_load, cnt_inc, cnt_clr, cnt_last;
    logic req_ok, round_adv;

    assign req_ok    = ((op_i == CIPH_FWD) || (op_i == CIPH_INV)) && $onehot(key_len_i);
    assign round_adv = (SecMasking != 0) ? sb_done_i : 1'b1;

    always_comb begin
        state_d          = state_q;
        crypt_d          = crypt_q;
        dkg_d            = dkg_q;
        reseed_d         = reseed_q;
        kclr_d           = kclr_q;
        dclr_d           = dclr_q;
        alert_d          = alert_q;
        in_ready_o       = 1'b0;
        out_valid_o      = 1'b0;
        crypt_o          = 1'b0;
        dec_key_gen_o    = 1'b0;
        prng_reseed_o    = 1'b0;
        key_clear_o      = 1'b0;
        data_out_clear_o = 1'b0;
        reseed_req_o     = 1'b0;
        sb_en_o          = 1'b0;
        state_we_o       = 1'b0;
        key_we_o         = 1'b0;
        state_clr_o      = 1'b0;
        key_clr_o        = 1'b0;
        cnt_load         = 1'b0;
        cnt_inc          = 1'b0;
        cnt_clr          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    crypt_d  = crypt_i;
                    dkg_d    = dec_key_gen_i;
                    reseed_d = prng_reseed_i;
                    kclr_d   = key_clear_i;
                    dclr_d   = data_out_clear_i;
                    cnt_load = 1'b1;
                    if (!req_ok) begin
                        state_d = ST_ERROR;
                        alert_d = 1'b1;
                    end else if (prng_reseed_i) begin
                        state_d = ST_RESEED;
                    end else begin
                        state_d = route(key_clear_i, data_out_clear_i, crypt_i, dec_key_gen_i);
                    end
                end
            end
            ST_RESEED: begin
                reseed_req_o = 1'b1;
                if (reseed_ack_i) begin
                    state_d = route(kclr_q, dclr_q, crypt_q, dkg_q);
                end
            end
            ST_CLEAR: begin
                state_clr_o = dclr_q;
                key_clr_o   = kclr_q;
                crypt_d     = 1'b0;
                dkg_d       = 1'b0;
                state_d     = ST_FINISH;
            end
            ST_INIT: begin
                key_we_o   = 1'b1;
                state_we_o = crypt_q;
                state_d    = ST_ROUND;
            end
            ST_ROUND: begin
                sb_en_o = (SecMasking != 0);
                if (round_adv) begin
                    key_we_o   = 1'b1;
                    state_we_o = crypt_q;
                    cnt_inc    = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                out_valid_o      = 1'b1;
                crypt_o          = crypt_q;
                dec_key_gen_o    = dkg_q;
                prng_reseed_o    = reseed_q;
                key_clear_o      = kclr_q;
                data_out_clear_o = dclr_q;
                if (out_ready_i) begin
                    state_d  = ST_IDLE;
                    crypt_d  = 1'b0;
                    dkg_d    = 1'b0;
                    reseed_d = 1'b0;
                    kclr_d   = 1'b0;
                    dclr_d   = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            ST_ERROR: begin
                alert_d = 1'b1;
            end
            default: begin
                state_d = ST_ERROR;
                alert_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            crypt_q  <= 1'b0;
            dkg_q    <= 1'b0;
            reseed_q <= 1'b0;
            kclr_q   <= 1'b0;
            dclr_q   <= 1'b0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            crypt_q  <= crypt_d;
            dkg_q    <= dkg_d;
            reseed_q <= reseed_d;
            kclr_q   <= kclr_d;
            dclr_q   <= dclr_d;
            alert_q  <= alert_d;
        end
    end

    assign alert_o = alert_q;

    aes_cipher_round_cnt u_round_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (cnt_load),
        .key_len_i (key_len_i),
        .inc_i     (cnt_inc),
        .clr_i     (cnt_clr),
        .round_o   (round_o),
        .last_o    (cnt_last)
    );

`ifdef AES_CIPHER_RESP_PERF_CNT_EN
    logic [PerfCntWidth-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if ((state_q != ST_IDLE) && (busy_q != {PerfCntWidth{1'b1}})) begin
            busy_d = busy_q + {{(PerfCntWidth-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_cycles_o = busy_q;
`else
    assign busy_cycles_o = '0;
`endif

endmodule

`default_nettype wire
